// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: branch/jump opcodes, branch-unit FSM states, PC reset value.
package lc3_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'b00,
    OP_JMP  = 2'b01,
    OP_JSR  = 2'b10,
    OP_JSRR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EVAL   = 2'b01,
    S_UPDATE = 2'b10
  } bpu_state_t;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h3000;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch resolution: condition test against NZP and redirect target.
module branch_target_calc
  import lc3_pkg::*;
(
  input  op_t         op_i,
  input  logic [11:0] ir_i,
  input  logic [15:0] base_r_i,
  input  logic [2:0]  nzp_i,
  input  logic [15:0] old_pc_i,
  output logic        cond_o,
  output logic [15:0] target_o
);

  logic signed [15:0] off9_s;
  logic signed [15:0] off11_s;

  assign off9_s  = {{7{ir_i[8]}}, ir_i[8:0]};
  assign off11_s = {{5{ir_i[10]}}, ir_i[10:0]};

  always_comb begin
    cond_o   = 1'b1;
    target_o = base_r_i;
    case (op_i)
      OP_BR: begin
        cond_o   = |(ir_i[11:9] & nzp_i);
        target_o = old_pc_i + off9_s;
      end
      OP_JSR:  target_o = old_pc_i + off11_s;
      default: target_o = base_r_i;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register owner: resolves BR/JMP/JSR/JSRR via IDLE->EVAL->UPDATE and drives the R7 link.
module branch_pc_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [15:0]      IR,
  input  logic [15:0]      BaseR,
  input  logic [2:0]       NZP,
  input  logic             Inc_PC,
  input  logic             Load_PC,
  input  logic [15:0]      PC_In,
  output logic [15:0]      PC,
  output logic             Busy,
  output logic             Done,
  output logic             Taken,
  output logic [15:0]      Link,
  output logic             Link_We,
  output logic [CNT_W-1:0] Taken_Cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  bpu_state_t       state_q, state_d;
  op_t              op_q, op_d;
  logic [11:0]      ir_q, ir_d;
  logic [15:0]      baser_q, baser_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [15:0]      old_pc_q, old_pc_d;
  logic [15:0]      pc_q, pc_d;
  logic             cond_q, cond_d;
  logic [15:0]      target_q, target_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [15:0]      link_q, link_d;
  logic             link_we_q, link_we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             calc_cond;
  logic [15:0]      calc_target;

  // Opcode field is decoded by the control FSM; only the operand bits matter here.
  logic unused_ir_hi;
  assign unused_ir_hi = ^IR[15:12];

  branch_target_calc u_calc (
    .op_i     (op_q),
    .ir_i     (ir_q),
    .base_r_i (baser_q),
    .nzp_i    (nzp_q),
    .old_pc_i (old_pc_q),
    .cond_o   (calc_cond),
    .target_o (calc_target)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ir_d      = ir_q;
    baser_d   = baser_q;
    nzp_d     = nzp_q;
    old_pc_d  = old_pc_q;
    pc_d      = pc_q;
    cond_d    = cond_q;
    target_d  = target_q;
    done_d    = 1'b0;
    taken_d   = 1'b0;
    link_d    = link_q;
    link_we_d = 1'b0;
    cnt_d     = cnt_q;

    // A direct PC load overrides and abandons any in-flight resolution.
    if (Load_PC) begin
      pc_d    = PC_In;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_d     = op_t'(Op);
            ir_d     = IR[11:0];
            baser_d  = BaseR;
            nzp_d    = NZP;
            old_pc_d = pc_q;
            state_d  = S_EVAL;
          end else if (Inc_PC) begin
            pc_d = pc_q + 16'd1;
          end
        end
        S_EVAL: begin
          cond_d   = calc_cond;
          target_d = calc_target;
          state_d  = S_UPDATE;
        end
        S_UPDATE: begin
          if (cond_q) begin
            pc_d  = target_q;
            cnt_d = sat_inc(cnt_q);
          end
          done_d  = 1'b1;
          taken_d = cond_q;
          if (op_q == OP_JSR || op_q == OP_JSRR) begin
            link_d    = old_pc_q;
            link_we_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_BR;
      ir_q      <= '0;
      baser_q   <= '0;
      nzp_q     <= '0;
      old_pc_q  <= '0;
      pc_q      <= PC_RESET;
      cond_q    <= 1'b0;
      target_q  <= '0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      link_q    <= '0;
      link_we_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ir_q      <= ir_d;
      baser_q   <= baser_d;
      nzp_q     <= nzp_d;
      old_pc_q  <= old_pc_d;
      pc_q      <= pc_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      link_q    <= link_d;
      link_we_q <= link_we_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PC        = pc_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign Taken     = taken_q;
  assign Link      = link_q;
  assign Link_We   = link_we_q;
  assign Taken_Cnt = cnt_q;

endmodule
